muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width (any even value >= 8).
REQ-002 SHALL have port: clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port: op  input  3  RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: opA  input  XLEN  rs1 value (multiplicand/dividend).
REQ-007 SHALL have port: opB  input  XLEN  rs2 value (multiplier/divisor).
REQ-008 SHALL have port: flush  input  1  abort of the in-flight operation.
REQ-009 SHALL have port: busy  output  1  high while an operation is in flight; the core stalls its PC on it.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; res is valid in that cycle.
REQ-011 SHALL have port: res  output  XLEN  result; held until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FINISH.
REQ-013 In IDLE with start=1 and flush=0, SHALL latch op, latch operand magnitudes and result-sign flags, clear the counter, and go to CALC.
  - Signed sources: MULH, MULHSU (opA only), DIV, REM.
REQ-014 In CALC, SHALL process one bit per cycle for exactly XLEN cycles, then go to FINISH.
  - Multiply: shift-add.
  - Divide: restoring.
REQ-015 In FINISH, SHALL apply sign correction and special cases, load res, assert done for that cycle only, and go to IDLE.
REQ-016 Latency SHALL be fixed: done asserted XLEN+1 cycles after the accept edge.
  - XLEN=32: the 34th cycle counting the accept cycle as 1.
  - Latency is identical for every op and operand value.
REQ-017 busy SHALL be 1 in CALC and FINISH and 0 in IDLE; it rises the cycle after accept.
REQ-018 start while busy=1 SHALL be ignored; inputs SHALL be sampled only at accept.
REQ-019 A new start SHALL be accepted in the IDLE cycle immediately following FINISH.
REQ-020 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-021 DIV/DIVU SHALL return the quotient truncated toward zero; REM/REMU SHALL return a remainder with the sign of the dividend.
REQ-022 Divisor = 0: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return opA unchanged.
REQ-023 Signed overflow (opA = most negative, opB = all-ones): DIV SHALL return opA; REM SHALL return 0.
REQ-024 flush=1 in CALC or FINISH SHALL return to IDLE at the next edge with no done pulse and res unchanged.
  - flush in FINISH suppresses that cycle's done and res load.
REQ-025 flush=1 together with start in IDLE SHALL prevent acceptance.
REQ-026 No combinational path SHALL exist from inputs to busy, done or res.

Reset
REQ-027 While rst=1 at an edge, SHALL enter IDLE with busy=0, done=0, res=0, and clear the counter and all datapath registers; this overrides start and flush.
REQ-028 rst=1 mid-operation SHALL abort it with no done pulse; the first start after rst falls SHALL be accepted normally.

Verification (XLEN=32)
REQ-029 MUL opA=7, opB=0xFFFFFFFD -> res 0xFFFFFFEB; done exactly 33 cycles after accept edge; busy high for 33 cycles.
REQ-030 MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-033 Back-to-back ops:
  - MUL 3*4 accepted; start with MUL 9*9 pulsed 5 cycles later -> ignored; single done with res 12.
  - Next start in the cycle after done -> accepted; res 81 after 33 more cycles.
REQ-034 Abort cases:
  - DIV accepted, flush at cycle 10 -> busy=0 next cycle; no done; res keeps prior value.
  - Repeat with rst at cycle 10 -> res=0, busy=0, done=0.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide, one bit per cycle, fixed latency.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int            CW     = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

    localparam logic [2:0] C_MUL    = 3'b000;
    localparam logic [2:0] C_MULH   = 3'b001;
    localparam logic [2:0] C_MULHSU = 3'b010;
    localparam logic [2:0] C_MULHU  = 3'b011;
    localparam logic [2:0] C_DIV    = 3'b100;
    localparam logic [2:0] C_DIVU   = 3'b101;
    localparam logic [2:0] C_REM    = 3'b110;
    localparam logic [2:0] C_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_neg;
    logic            r_div0;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_res;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg_in;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    always_comb begin
        w_sgn_a  = opA[XLEN-1] & ((op == C_MULH) || (op == C_MULHSU) ||
                                  (op == C_DIV)  || (op == C_REM));
        w_sgn_b  = opB[XLEN-1] & ((op == C_MULH) || (op == C_DIV) || (op == C_REM));
        w_mag_a  = w_sgn_a ? (~opA + 1'b1) : opA;
        w_mag_b  = w_sgn_b ? (~opB + 1'b1) : opB;
        // Remainder follows the dividend's sign; everything else follows the product rule
        w_neg_in = (op == C_REM) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);

        // Shift-add step: r_lo holds the multiplier, low product bits shift in from the top
        w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_a : {XLEN{1'b0}})};

        // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_diff  = w_div_shift[XLEN-1:0] - r_b;

        w_prod     = {r_hi, r_lo};
        w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
        // Divide-by-zero quotient must stay all-ones regardless of dividend sign
        w_quot     = r_div0 ? {XLEN{1'b1}} : (r_neg ? (~r_lo + 1'b1) : r_lo);
        w_rem      = r_neg ? (~r_hi + 1'b1) : r_hi;

        case (r_op)
            C_MUL:                      w_result = w_prod_fix[XLEN-1:0];
            C_MULH, C_MULHSU, C_MULHU:  w_result = w_prod_fix[2*XLEN-1:XLEN];
            C_DIV, C_DIVU:              w_result = w_quot;
            default:                    w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg   <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= op;
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_neg   <= w_neg_in;
                        r_div0  <= (opB == '0);
                        r_hi    <= '0;
                        r_lo    <= op[2] ? w_mag_a : w_mag_b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op[2]) begin
                            r_hi <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                        end else begin
                            r_hi <= w_mul_sum[XLEN:1];
                            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_res  <= w_result;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Self-checking bench for muldiv_unit (XLEN=32) with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin up = ua * ub;          return up[31:0];  end
            3'd1: begin sp = sa * sb;          return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub;          return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub;
                return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub;
                return up[31:0];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Accept one operation, scramble inputs (with stray starts) while busy, check result and timing
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clk); #1;
        check({tag, "/busy_rise"}, {31'd0, busy}, 32'd1);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom);
            opA   = $urandom;
            opB   = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "/latency"}, lat, 32'd33);
        check({tag, "/busy_cycles"}, bcnt, 32'd33);
        check({tag, "/res"}, res, exp);
        check({tag, "/busy_at_done"}, {31'd0, busy}, 32'd0);
        last_res = exp;
    endtask

    task automatic accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
    endtask

    initial begin
        int          nd;
        int          lat;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] corner [4];

        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h0000_0001;

        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'd0; opA = 32'd5; opB = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/done", {31'd0, done}, 32'd0);
        check("reset/res", res, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        last_res = 32'd0;

        do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_-7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_-7_2");
        do_op(3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, "divu_big_2");
        do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
        do_op(3'd7, 32'd5,         32'd0,         32'd5,         "remu_by0");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_neg_by0");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_neg_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

        // Stray start mid-operation must not disturb the in-flight MUL
        accept(3'd0, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd0; opA = 32'd9; opB = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b/first_latency", lat, 32'd33);
        check("b2b/first_res", res, 32'd12);
        do_op(3'd0, 32'd9, 32'd9, 32'd81, "b2b/second");

        // Start with flush in IDLE is refused
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; opA = 32'd2; opB = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush/busy", {31'd0, busy}, 32'd0);
        count_done(40, nd);
        check("idle_flush/no_done", nd, 32'd0);

        // Flush in CALC
        accept(3'd4, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc/busy", {31'd0, busy}, 32'd0);
        count_done(40, nd);
        check("flush_calc/no_done", nd, 32'd0);
        check("flush_calc/res_kept", res, last_res);

        // Flush in the FINISH cycle suppresses done and the result load
        accept(3'd0, 32'd6, 32'd7);
        repeat (32) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_finish/done", {31'd0, done}, 32'd0);
        check("flush_finish/busy", {31'd0, busy}, 32'd0);
        count_done(5, nd);
        check("flush_finish/no_done", nd, 32'd0);
        check("flush_finish/res_kept", res, last_res);

        // Reset mid-operation
        accept(3'd4, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_abort/busy", {31'd0, busy}, 32'd0);
        check("rst_abort/done", {31'd0, done}, 32'd0);
        check("rst_abort/res", res, 32'd0);
        count_done(40, nd);
        check("rst_abort/no_done", nd, 32'd0);
        do_op(3'd4, 32'd100, 32'd7, 32'd14, "after_rst");

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            do_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
